ask_frame_sequencer: RTL

Frame-level controller that drives the DDS ASK modulator's i_freq_word and i_data inputs. Accepts payload bytes over a valid/ready stream and emits one OOK bit stream per frame: preamble, sync byte, payload (MSB first), then a carrier-off guard interval. Each bit lasts a programmable number of clocks. Sits between the host/UART byte source and the modulator in the ffpga top level.

---
 rtl/ask_pkg.sv | 24 ++
 rtl/ask_frame_sequencer_if.sv | 16 +
 rtl/ask_bit_timer.sv | 31 +++
 rtl/ask_frame_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ask_pkg.sv
// Shared constants, state encoding and helpers for the ASK frame sequencer
// and its bit timer.
package ask_pkg;

   localparam int          PERIOD_W      = 16;
   localparam int          FREQ_W        = 6;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SYNC_BYTE     = 8'hD3;
   localparam int          GUARD_BITS    = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SYNC     = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_GUARD    = 3'd4
   } state_t;

   // States in which o_data carries a shifted-out frame bit.
   function automatic logic is_bit_state(input state_t s);
      return (s == ST_PREAMBLE) || (s == ST_SYNC) || (s == ST_PAYLOAD);
   endfunction

endpackage

// File: rtl/ask_frame_sequencer_if.sv
// Payload byte stream between the host/UART byte source and the frame
// sequencer.
interface ask_frame_sequencer_if;

   // A byte transfers on the rising clk edge where i_tx_valid && o_tx_ready.
   // i_tx_data/i_tx_last are meaningful only while i_tx_valid is high, and the
   // source holds them stable until the transfer happens.
   logic [7:0] i_tx_data;
   logic       i_tx_valid;
   logic       i_tx_last;
   logic       o_tx_ready;

   modport master (output i_tx_data, i_tx_valid, i_tx_last, input o_tx_ready);
   modport slave  (input i_tx_data, i_tx_valid, i_tx_last, output o_tx_ready);

endinterface

// File: rtl/ask_bit_timer.sv
// Loadable period down-counter: o_tick is high for the last clock of every
// P-clock bit while enabled. A period of 0 behaves as 1.
module ask_bit_timer #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_period,
   output logic         o_tick
);

   logic [W-1:0] cnt;
   logic [W-1:0] reload;

   assign reload = (i_period == '0) ? '0 : i_period - W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (i_load) begin
         cnt <= reload;
      end else if (i_en) begin
         cnt <= (cnt == '0) ? reload : cnt - W'(1);
      end
   end

   assign o_tick = i_en && (cnt == '0);

endmodule

// File: rtl/ask_frame_sequencer.sv
// Frame controller for the DDS ASK modulator: preamble, sync byte, payload
// (MSB first) and a carrier-off guard, each bit lasting a programmable period.
module ask_frame_sequencer #(
   parameter int         PERIOD_W   = ask_pkg::PERIOD_W,
   parameter int         FREQ_W     = ask_pkg::FREQ_W,
   parameter logic [7:0] SYNC_BYTE  = ask_pkg::SYNC_BYTE,
   parameter int         GUARD_BITS = ask_pkg::GUARD_BITS
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [PERIOD_W-1:0] i_cfg_bit_period,
   input  logic [FREQ_W-1:0]   i_cfg_freq_word,
   input  logic [3:0]          i_cfg_preamble_bytes,
   ask_frame_sequencer_if.slave tx,
   output logic [FREQ_W-1:0]   o_freq_word,
   output logic                o_data,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_underrun,
   output ask_pkg::state_t     o_state
);

   import ask_pkg::*;

   localparam int GW = $clog2(GUARD_BITS + 1);

   state_t              state, state_next;
   logic [PERIOD_W-1:0] period_r, period_cfg;
   logic [2:0]          bit_idx;
   logic [GW-1:0]       guard_idx;
   logic [3:0]          pre_left;
   logic [7:0]          sh;
   logic [7:0]          hold_data;
   logic                hold_valid, hold_last, last_acc, cur_last;
   logic                accept, tick, boundary, have_byte, bypass;
   logic                start, load_en, load_payload, to_guard, underrun_set, done_set;
   logic [7:0]          load_val, next_byte, first_byte;
   logic                next_last;

   assign period_cfg = (i_cfg_bit_period == '0) ? PERIOD_W'(1) : i_cfg_bit_period;
   assign first_byte = (i_cfg_preamble_bytes == 4'd0) ? SYNC_BYTE : PREAMBLE_BYTE;

   // Gated by reset so the source sees ready low while the block is held in reset.
   assign tx.o_tx_ready = i_rst_n && !hold_valid && !last_acc && (state != ST_GUARD);
   assign accept        = tx.i_tx_valid && tx.o_tx_ready;

   // A byte arriving on the boundary edge itself bypasses the holding register.
   assign have_byte = hold_valid || accept;
   assign next_byte = hold_valid ? hold_data : tx.i_tx_data;
   assign next_last = hold_valid ? hold_last : tx.i_tx_last;
   assign bypass    = load_payload && !hold_valid;
   assign boundary  = tick && is_bit_state(state) && (bit_idx == 3'd7);

   ask_bit_timer #(.W(PERIOD_W)) u_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (start),
      .i_en     (state != ST_IDLE),
      .i_period (start ? period_cfg : period_r),
      .o_tick   (tick)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next   = state;
      start        = 1'b0;
      load_en      = 1'b0;
      load_val     = sh;
      load_payload = 1'b0;
      to_guard     = 1'b0;
      underrun_set = 1'b0;
      done_set     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               start      = 1'b1;
               state_next = (i_cfg_preamble_bytes == 4'd0) ? ST_SYNC : ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            if (boundary) begin
               load_en = 1'b1;
               if (pre_left == 4'd1) begin
                  state_next = ST_SYNC;
                  load_val   = SYNC_BYTE;
               end else begin
                  load_val   = PREAMBLE_BYTE;
               end
            end
         end
         ST_SYNC, ST_PAYLOAD: begin
            if (boundary) begin
               if ((state == ST_PAYLOAD) && cur_last) begin
                  to_guard   = 1'b1;
                  state_next = ST_GUARD;
               end else if (have_byte) begin
                  load_en      = 1'b1;
                  load_payload = 1'b1;
                  load_val     = next_byte;
                  state_next   = ST_PAYLOAD;
               end else begin
                  to_guard     = 1'b1;
                  underrun_set = 1'b1;
                  state_next   = ST_GUARD;
               end
            end
         end
         ST_GUARD: begin
            if (tick && (guard_idx == GW'(GUARD_BITS - 1))) begin
               done_set   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         period_r    <= '0;
         o_freq_word <= '0;
         o_data      <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_underrun  <= 1'b0;
         bit_idx     <= '0;
         guard_idx   <= '0;
         pre_left    <= '0;
         sh          <= '0;
         hold_data   <= '0;
         hold_valid  <= 1'b0;
         hold_last   <= 1'b0;
         last_acc    <= 1'b0;
         cur_last    <= 1'b0;
      end else begin
         o_done     <= done_set;
         o_underrun <= underrun_set;

         if (start) begin
            period_r    <= period_cfg;
            o_freq_word <= i_cfg_freq_word;
            pre_left    <= i_cfg_preamble_bytes;
            o_busy      <= 1'b1;
            sh          <= first_byte;
            o_data      <= first_byte[7];
            bit_idx     <= 3'd0;
         end else if (load_en) begin
            sh      <= load_val;
            o_data  <= load_val[7];
            bit_idx <= 3'd0;
            if (state == ST_PREAMBLE) pre_left <= pre_left - 4'd1;
         end else if (to_guard) begin
            o_data    <= 1'b0;
            guard_idx <= '0;
         end else if (tick && is_bit_state(state)) begin
            sh      <= {sh[6:0], 1'b0};
            o_data  <= sh[6];
            bit_idx <= bit_idx + 3'd1;
         end else if (tick && (state == ST_GUARD)) begin
            guard_idx <= guard_idx + GW'(1);
         end

         if (done_set) o_busy <= 1'b0;

         // Holding register: accept can only happen while it is empty.
         if (load_payload) cur_last <= next_last;
         if (load_payload && hold_valid) hold_valid <= 1'b0;
         if (accept && !bypass) begin
            hold_valid <= 1'b1;
            hold_data  <= tx.i_tx_data;
            hold_last  <= tx.i_tx_last;
         end

         if (done_set)                    last_acc <= 1'b0;
         else if (accept && tx.i_tx_last) last_acc <= 1'b1;
      end
   end

   assign o_state = state;

endmodule
